fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the MIPS pipeline. It owns the PC, issues word requests to instruction memory over a req/ack handshake, and captures each returned instruction into the IF/ID register. It presents the decoded register fields to the decode stage and the raw 16-bit immediate to the sign-extend stage. It honours stall, flush and branch redirect from the later stages.

---
 rtl/mips_defs.sv | 26 ++
 rtl/if_id_reg.sv | 52 +++++
 rtl/fetch_stage.sv | 126 ++++++++++++
 tb/tb_fetch_stage.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared constants for the MIPS pipeline: widths, reset PC, instruction field
// positions and the fetch FSM state encoding.
package mips_defs;

    localparam int          ADDR_W    = 32;
    localparam int          INSTR_W   = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds the fetched instruction and its PC+4, and
// splits the instruction into the fields used by decode and sign-extend.
module if_id_reg
    import mips_defs::*;
#(
    parameter int ADDR_W = mips_defs::ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [ADDR_W-1:0]  i_pc_plus4,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc_plus4,
    output logic [4:0]         o_rs,
    output logic [4:0]         o_rt,
    output logic [4:0]         o_rd,
    output logic [15:0]        o_imm
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc_plus4;

    // Clearing zeroes the instruction itself, so every derived field reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= '0;
        end else if (i_clear) begin
            r_valid    <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= '0;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_instr    <= i_instr;
            r_pc_plus4 <= i_pc_plus4;
        end
    end

    assign o_valid    = r_valid;
    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_rs       = r_instr[RS_MSB:RS_LSB];
    assign o_rt       = r_instr[RT_MSB:RT_LSB];
    assign o_rd       = r_instr[RD_MSB:RD_LSB];
    assign o_imm      = r_instr[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, runs the imem req/ack handshake and
// feeds the IF/ID register, honouring branch redirect, flush and stall.
module fetch_stage
    import mips_defs::*;
#(
    parameter int                ADDR_W   = mips_defs::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(mips_defs::RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc_plus4,
    output logic [4:0]        id_rs,
    output logic [4:0]        id_rt,
    output logic [4:0]        id_rd,
    output logic [15:0]       id_imm
);

    fetch_state_t       r_state;
    logic               r_boot_done;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_drain_addr;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [ADDR_W-1:0]  r_skid_pc4;

    logic               w_pc_plus4_valid;
    logic [ADDR_W-1:0]  w_pc_plus4;
    logic               w_fetch_ok;
    logic               w_advance;
    logic               w_load;
    logic               w_clear;
    logic [INSTR_W-1:0] w_id_instr;
    logic [ADDR_W-1:0]  w_id_pc4;

    assign w_pc_plus4 = r_pc + ADDR_W'(4);
    assign w_fetch_ok = (r_state == ST_REQ) && imem_ack;

    // In DRAIN the old address stays on the bus even though pc already holds the target.
    assign imem_req  = (r_state == ST_REQ) || (r_state == ST_DRAIN);
    assign imem_addr = (r_state == ST_DRAIN) ? r_drain_addr : r_pc;

    assign w_pc_plus4_valid = w_fetch_ok || (r_state == ST_HOLD);
    assign w_advance  = !branch_taken && !flush && !stall;
    assign w_load     = w_advance && w_pc_plus4_valid;
    assign w_clear    = branch_taken || flush || (!stall && !w_pc_plus4_valid);
    assign w_id_instr = (r_state == ST_HOLD) ? r_skid_instr : imem_rdata;
    assign w_id_pc4   = (r_state == ST_HOLD) ? r_skid_pc4   : w_pc_plus4;

    // IDLE spans the reset-release edge plus one more, so the first request
    // rises on the second edge after rst_n deasserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_boot_done  <= 1'b0;
            r_pc         <= RESET_PC;
            r_drain_addr <= RESET_PC;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc4   <= '0;
        end else if (branch_taken) begin
            r_pc         <= branch_target;
            r_boot_done  <= 1'b1;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc4   <= '0;
            if (r_state == ST_REQ && !imem_ack) begin
                r_drain_addr <= r_pc;
                r_state      <= ST_DRAIN;
            end else if (r_state == ST_DRAIN && !imem_ack) begin
                r_state <= ST_DRAIN;
            end else begin
                r_state <= ST_REQ;
            end
        end else if (!flush) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_boot_done) r_state <= ST_REQ;
                    else             r_boot_done <= 1'b1;
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        r_pc <= w_pc_plus4;
                        if (stall) begin
                            r_skid_instr <= imem_rdata;
                            r_skid_pc4   <= w_pc_plus4;
                            r_state      <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) r_state <= ST_REQ;
                end
                ST_DRAIN: begin
                    if (imem_ack) r_state <= ST_REQ;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    if_id_reg #(
        .ADDR_W(ADDR_W)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_clear    (w_clear),
        .i_instr    (w_id_instr),
        .i_pc_plus4 (w_id_pc4),
        .o_valid    (id_valid),
        .o_instr    (id_instr),
        .o_pc_plus4 (id_pc_plus4),
        .o_rs       (id_rs),
        .o_rt       (id_rt),
        .o_rd       (id_rd),
        .o_imm      (id_imm)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic, all
// checked against a queue-based behavioural model of the fetch stage.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_imm;

    // second instance with a high reset PC and a zero-wait addr-as-data memory
    logic        hi_req;
    logic [31:0] hi_addr;
    logic        hi_valid;
    logic [31:0] hi_instr;
    logic [31:0] hi_pc4;
    logic [4:0]  hi_rs, hi_rt, hi_rd;
    logic [15:0] hi_imm;

    always #5 clk = ~clk;

    fetch_stage u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm)
    );

    fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
        .clk(clk), .rst_n(rst_n),
        .imem_req(hi_req), .imem_addr(hi_addr),
        .imem_ack(hi_req), .imem_rdata(hi_addr),
        .stall(1'b0), .flush(1'b0),
        .branch_taken(1'b0), .branch_target(32'h0),
        .id_valid(hi_valid), .id_instr(hi_instr), .id_pc_plus4(hi_pc4),
        .id_rs(hi_rs), .id_rt(hi_rt), .id_rd(hi_rd), .id_imm(hi_imm)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } word_t;

    int          m_idle_left;
    bit          m_discard;
    logic [31:0] m_old_addr;
    logic [31:0] m_pc;
    word_t       q_skid[$];
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;

    bit          addr_data_mode;
    bit          force_data;
    logic [31:0] force_word;

    function automatic bit exp_req();
        return (m_idle_left == 0) && (q_skid.size() == 0);
    endfunction

    function automatic logic [31:0] exp_addr();
        return m_discard ? m_old_addr : m_pc;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return addr_data_mode ? a : ((a * 32'h9E37_79B1) ^ 32'h1357_2468);
    endfunction

    task automatic model_reset();
        m_idle_left = 2;
        m_discard   = 1'b0;
        m_old_addr  = 32'h0;
        m_pc        = 32'h0;
        q_skid.delete();
        m_valid = 1'b0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
    endtask

    task automatic model_clear();
        m_valid = 1'b0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
    endtask

    task automatic model_load(input logic [31:0] instr, input logic [31:0] pc4);
        m_valid = 1'b1;
        m_instr = instr;
        m_pc4   = pc4;
        $display("IFID  pc=%h instr=%h", pc4 - 32'd4, instr);
    endtask

    task automatic check_outputs();
        check_eq("imem_req",    {31'h0, imem_req}, {31'h0, exp_req()});
        check_eq("imem_addr",   imem_addr,         exp_addr());
        check_eq("id_valid",    {31'h0, id_valid}, {31'h0, m_valid});
        check_eq("id_instr",    id_instr,          m_instr);
        check_eq("id_pc_plus4", id_pc_plus4,       m_pc4);
        check_eq("id_rs",       {27'h0, id_rs},    {27'h0, m_instr[25:21]});
        check_eq("id_rt",       {27'h0, id_rt},    {27'h0, m_instr[20:16]});
        check_eq("id_rd",       {27'h0, id_rd},    {27'h0, m_instr[15:11]});
        check_eq("id_imm",      {16'h0, id_imm},   {16'h0, m_instr[15:0]});
    endtask

    // One clock: check at negedge, drive inputs, advance the model, cross one edge.
    // ack_mode: 0 = no ack, 1 = ack whenever a request is expected, 2 = ack regardless.
    task automatic step(input bit br, input logic [31:0] tgt, input bit fl,
                        input bit st, input int ack_mode);
        bit          ereq;
        bit          ack;
        logic [31:0] a;
        logic [31:0] rd;
        word_t       w;
        check_outputs();
        ereq = exp_req();
        a    = exp_addr();
        ack  = (ack_mode == 2) || (ack_mode == 1 && ereq);
        rd   = force_data ? force_word : mem_word(a);
        branch_taken  = br;
        branch_target = tgt;
        flush         = fl;
        stall         = st;
        imem_ack      = ack;
        imem_rdata    = rd;

        if (m_idle_left > 0) begin
            m_idle_left--;
            if (br) begin
                m_idle_left = 0;
                m_pc        = tgt;
            end
            model_clear();
        end else if (br) begin
            if (ereq && !ack) begin
                if (!m_discard) m_old_addr = m_pc;
                m_discard = 1'b1;
            end else begin
                m_discard = 1'b0;
            end
            m_pc = tgt;
            q_skid.delete();
            model_clear();
        end else if (fl) begin
            model_clear();
        end else if (m_discard) begin
            if (ack) m_discard = 1'b0;
            if (!st) model_clear();
        end else if (q_skid.size() != 0) begin
            if (!st) begin
                w = q_skid.pop_front();
                model_load(w.instr, w.pc4);
            end
        end else begin
            if (ack) begin
                if (st) q_skid.push_back(word_t'{instr: rd, pc4: m_pc + 32'd4});
                else    model_load(rd, m_pc + 32'd4);
                m_pc = m_pc + 32'd4;
            end else if (!st) begin
                model_clear();
            end
        end

        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] saved;
        bit          r_br, r_fl, r_st;
        logic [31:0] r_tgt;
        int          r_ack;

        rst_n = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        stall = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0;
        addr_data_mode = 1'b1;
        force_data = 1'b0;
        force_word = 32'h0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs();
        check_eq("rst_hi_addr", hi_addr, 32'hFFFF_FFF8);
        rst_n = 1'b1;

        // zero-wait memory returning addr-as-data
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0, 1);
            case (k)
                1: check_eq("boot_req_e1", {31'h0, imem_req}, 32'h0);
                2: begin
                    check_eq("boot_req_e2", {31'h0, imem_req}, 32'h1);
                    check_eq("hi_addr_e2", hi_addr, 32'hFFFF_FFF8);
                end
                3: begin
                    check_eq("boot_valid_e3", {31'h0, id_valid}, 32'h1);
                    check_eq("boot_instr_e3", id_instr, 32'h0);
                    check_eq("hi_addr_e3", hi_addr, 32'hFFFF_FFFC);
                end
                4: begin
                    check_eq("boot_instr_e4", id_instr, 32'h4);
                    check_eq("hi_addr_e4", hi_addr, 32'h0);
                end
                5: check_eq("boot_instr_e5", id_instr, 32'h8);
                6: check_eq("boot_instr_e6", id_instr, 32'hC);
                default: ;
            endcase
        end

        // stall while a word returns: skid it, hold IF/ID, release it later
        addr_data_mode = 1'b0;
        saved = id_instr;
        force_data = 1'b1;
        force_word = 32'h2008_FFFF;
        step(1'b0, 32'h0, 1'b0, 1'b1, 1);
        force_data = 1'b0;
        check_eq("hold_req", {31'h0, imem_req}, 32'h0);
        check_eq("hold_instr", id_instr, saved);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1);
        check_eq("hold_instr3", id_instr, saved);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1);
        check_eq("rel_instr", id_instr, 32'h2008_FFFF);
        check_eq("rel_imm", {16'h0, id_imm}, 32'h0000_FFFF);
        check_eq("rel_rt", {27'h0, id_rt}, 32'h8);
        check_eq("rel_valid", {31'h0, id_valid}, 32'h1);

        // branch during a delayed ack: drain the old word, then fetch the target
        step(1'b0, 32'h0, 1'b0, 1'b0, 1);
        saved = imem_addr;
        step(1'b1, 32'h0000_0100, 1'b0, 1'b0, 0);
        check_eq("drain_req", {31'h0, imem_req}, 32'h1);
        check_eq("drain_addr", imem_addr, saved);
        step(1'b0, 32'h0, 1'b0, 1'b0, 0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1);
        check_eq("drain_valid", {31'h0, id_valid}, 32'h0);
        check_eq("drain_next_addr", imem_addr, 32'h0000_0100);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1);
        check_eq("tgt_pc4", id_pc_plus4, 32'h0000_0104);

        // flush and stall together
        step(1'b0, 32'h0, 1'b0, 1'b0, 1);
        saved = imem_addr;
        step(1'b0, 32'h0, 1'b1, 1'b1, 1);
        check_eq("flush_valid", {31'h0, id_valid}, 32'h0);
        check_eq("flush_instr", id_instr, 32'h0);
        check_eq("flush_pc", imem_addr, saved);

        // reset while a request is outstanding, with a late ack
        step(1'b0, 32'h0, 1'b0, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check_eq("arst_req", {31'h0, imem_req}, 32'h0);
        check_eq("arst_addr", imem_addr, 32'h0);
        check_eq("arst_valid", {31'h0, id_valid}, 32'h0);
        check_eq("arst_instr", id_instr, 32'h0);
        model_reset();
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0, 2);
        step(1'b0, 32'h0, 1'b0, 1'b0, 2);
        check_eq("post_rst_req", {31'h0, imem_req}, 32'h1);
        check_eq("post_rst_addr", imem_addr, 32'h0);
        check_eq("post_rst_valid", {31'h0, id_valid}, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            r_br  = ($urandom % 16) == 0;
            r_tgt = (($urandom % 8) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            r_fl  = ($urandom % 12) == 0;
            r_st  = ($urandom % 4) == 0;
            r_ack = (($urandom % 3) != 0) ? 1 : 0;
            step(r_br, r_tgt, r_fl, r_st, r_ack);
        end
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
